// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage core: merges stall requests, turns MEM-stage
// exceptions/ERET into a flush, and defers that flush while a fetch is still on the bus.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [31:0] ERET_CODE  = 32'h0000_000e
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        flush_pending,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    localparam int unsigned STALL_W = 6;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned FCNT_W  = 16;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

    typedef enum logic {
        RUN        = 1'b0,
        FLUSH_WAIT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   target;
    logic [ADDR_W-1:0]   target_next;
    logic [ADDR_W-1:0]   exc_target;

    // Same-cycle stall/flush decode from the inputs and the current state.
    always_comb begin
        stall       = STALL_NONE;
        flush       = 1'b0;
        new_pc      = '0;
        state_next  = state;
        target_next = target;
        exc_target  = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;

        case (state)
            RUN: begin
                if (excepttype_i != '0) begin
                    if (!stallreq_from_if) begin
                        flush  = 1'b1;
                        new_pc = exc_target;
                    end else begin
                        // Fetch still in flight: freeze everything and remember where to go.
                        stall       = STALL_ALL;
                        target_next = exc_target;
                        state_next  = FLUSH_WAIT;
                    end
                end else if (stallreq_from_mem) begin
                    stall = STALL_MEM;
                end else if (stallreq_from_ex) begin
                    stall = STALL_EX;
                end else if (stallreq_from_id || stallreq_from_if) begin
                    stall = STALL_IF;
                end
            end
            FLUSH_WAIT: begin
                // MEM is frozen and re-presents its code, so only the fetch bus matters here.
                if (!stallreq_from_if) begin
                    flush      = 1'b1;
                    new_pc     = target;
                    state_next = RUN;
                end else begin
                    stall = STALL_ALL;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // State, latched redirect target and debug counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            target        <= '0;
            flush_pending <= 1'b0;
            stall_cycles  <= '0;
            flush_count   <= '0;
        end else begin
            state         <= state_next;
            target        <= target_next;
            flush_pending <= (state_next == FLUSH_WAIT);
            if (stall[0] && (stall_cycles != {ADDR_W{1'b1}})) begin
                stall_cycles <= stall_cycles + ADDR_W'(1);
            end
            if (flush) begin
                flush_count <= flush_count + FCNT_W'(1);
            end
        end
    end

endmodule
